// File: rtl/demux_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_stream_pkg : shared types for the registered stream demux     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package demux_stream_pkg;

  typedef enum logic {
    UNICAST   = 1'b0,
    MULTICAST = 1'b1
  } mode_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int DROP_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/demux_stream_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_stream_slot : one output channel register with EMPTY/FULL FSM |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module demux_stream_slot
  import demux_stream_pkg::*;
#(
  parameter int NR_OF_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic [NR_OF_BITS-1:0] data_i,
  output logic [NR_OF_BITS-1:0] data_o,
  output logic                  valid_o
);

  slot_state_e           state_q;
  logic [NR_OF_BITS-1:0] data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load_i) begin
            state_q <= SLOT_FULL;
            data_q  <= data_i;
          end
        end
        SLOT_FULL: begin
          // A load in the same cycle as a drain keeps the slot full.
          if (load_i) begin
            data_q <= data_i;
          end else if (drain_i) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = valid_o ? data_q : '0;

endmodule
`default_nettype wire

// File: rtl/registered_demux_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | registered_demux_stream : unicast/multicast stream demux, 1 cycle   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module registered_demux_stream
  import demux_stream_pkg::*;
#(
  parameter int nrOfBits     = 8,
  parameter int nrOfChannels = 16,
  parameter int nrOfSelBits  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             broadcast,
  input  logic [nrOfSelBits-1:0]           sel,
  input  logic [nrOfChannels-1:0]          mask,
  input  logic [nrOfBits-1:0]              demuxIn,
  input  logic                             inValid,
  output logic                             inReady,
  output logic [nrOfChannels*nrOfBits-1:0] demuxOut,
  output logic [nrOfChannels-1:0]          outValid,
  input  logic [nrOfChannels-1:0]          outReady,
  output logic [DROP_CNT_W-1:0]            dropCount
);

  if ((2 ** nrOfSelBits) < nrOfChannels) begin : g_param_check
    $error("nrOfSelBits too narrow for nrOfChannels");
  end

  mode_e                   mode;
  logic [nrOfChannels-1:0] target;
  logic [nrOfChannels-1:0] load;
  logic                    blocked;
  logic                    accept;
  logic [DROP_CNT_W-1:0]   drop_cnt_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_d;

  assign mode = mode_e'(broadcast);

  // Out-of-range sel matches no channel, leaving the target set empty.
  always_comb begin
    target = '0;
    for (int i = 0; i < nrOfChannels; i++) begin
      if (mode == MULTICAST) begin
        target[i] = mask[i];
      end else begin
        target[i] = (sel == nrOfSelBits'(i));
      end
    end
  end

  assign blocked = |(target & outValid & ~outReady);
  assign inReady = enable & ~reset & ~blocked;
  assign accept  = inValid & inReady;
  assign load    = accept ? target : '0;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && (target == '0) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dropCount = drop_cnt_q;

  for (genvar g = 0; g < nrOfChannels; g++) begin : g_slot
    demux_stream_slot #(
      .NR_OF_BITS(nrOfBits)
    ) u_slot (
      .clock  (clock),
      .reset  (reset),
      .load_i (load[g]),
      .drain_i(outReady[g]),
      .data_i (demuxIn),
      .data_o (demuxOut[g*nrOfBits +: nrOfBits]),
      .valid_o(outValid[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/registered_demux_stream.md
REGISTERED_DEMUX_STREAM -- requirements
Module: registered_demux_stream

Interface
REQ-001 The block SHALL have a single clock, `clock`; `reset` SHALL be synchronous and active-high.
REQ-002 Parameter nrOfBits, default 8: data width per channel (1..64).
REQ-003 Parameter nrOfChannels, default 16: output channel count (2..16).
REQ-004 Parameter nrOfSelBits, default 4: select width; SHALL satisfy 2^nrOfSelBits >= nrOfChannels.
REQ-005 Port clock, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port enable, input, 1: accept gate; 0 blocks new input, outputs still drain.
REQ-008 Port broadcast, input, 1: mode; 0 = unicast by sel, 1 = multicast by mask.
REQ-009 Port sel, input, nrOfSelBits: unicast destination index.
REQ-010 Port mask, input, nrOfChannels: multicast destination bitmap, bit i = channel i.
REQ-011 Port demuxIn, input, nrOfBits: input word.
REQ-012 Port inValid, input, 1: input word present.
REQ-013 Port inReady, output, 1: input word accepted this cycle when inValid=1.
REQ-014 Port demuxOut, output, nrOfChannels*nrOfBits: channel i occupies bits [i*nrOfBits +: nrOfBits].
REQ-015 Port outValid, output, nrOfChannels: per-channel word present.
REQ-016 Port outReady, input, nrOfChannels: per-channel consumer ready.
REQ-017 Port dropCount, output, 8: saturating count of discarded words.

Function
REQ-018 Target set T SHALL be {sel} when broadcast=0 and sel<nrOfChannels, mask when broadcast=1, empty otherwise.
REQ-019 inReady SHALL be combinational: enable AND, for every channel i in T, (outValid[i]=0 OR outReady[i]=1); empty T gives inReady=enable.
REQ-020 Accept = inValid AND inReady; on accept with non-empty T, every slot in T SHALL load demuxIn and set outValid=1 at the next edge (latency 1 cycle, no partial multicast).
REQ-021 On accept with empty T (sel out of range, or mask=0), the word SHALL be discarded and dropCount incremented, saturating at 255.
REQ-022 Slot not loaded this cycle: outValid[i]=1 and outReady[i]=1 SHALL clear outValid[i] at next edge.
REQ-023 Simultaneous drain and load on one slot: load wins; outValid stays 1, new data presented next cycle (full throughput, one word per cycle per channel).
REQ-024 demuxOut channel i SHALL read all zeros whenever outValid[i]=0.
REQ-025 Slots outside T SHALL hold state unchanged on an accept.
REQ-026 sel, mask, broadcast, demuxIn SHALL be sampled only on the accepting edge; changes while inReady=0 SHALL have no effect.
REQ-027 Each slot SHALL be a two-state machine EMPTY/FULL: EMPTY->FULL on load; FULL->EMPTY on drain without load; FULL->FULL on load.

Reset
REQ-028 reset=1 SHALL, at the next edge, clear all outValid to 0, all slot data to 0, dropCount to 0, discarding in-flight words; inReady SHALL be 0 while reset=1.
REQ-029 reset SHALL take priority over simultaneous accept or drain.

Structure
REQ-030 Mode encodings (UNICAST=0, MULTICAST=1) and dropCount width (8) SHALL live in shared package demux_stream_pkg.
REQ-031 The per-channel slot (data register, valid, EMPTY/FULL logic, zero gating) SHALL be sub-module demux_stream_slot, instantiated nrOfChannels times by generate.

Verification
REQ-032 Unicast: nrOfChannels=16, sel=5, demuxIn=0xA5, all outReady=0 -> next cycle outValid=0x0020, channel 5 = 0xA5, others 0; second word to sel=5 stalls inReady=0.
REQ-033 Multicast backpressure: mask=0x0006, channel 2 full with outReady[2]=0 -> inReady=0, neither channel 1 nor 2 loads; set outReady[2]=1 -> both load same word next edge.
REQ-034 Streaming: sel=3, outReady[3]=1 held, 10 back-to-back words 0x00..0x09 -> inReady constantly 1, channel 3 emits all 10 in order, one per cycle.
REQ-035 Drop: nrOfChannels=12, sel=14, 300 accepts -> no outValid asserted, dropCount reaches 255 and holds; also mask=0 accept increments dropCount.
REQ-036 Reset mid-operation: outValid=0x8001 with stalled outputs, reset pulsed one cycle -> outValid=0, demuxOut=0, dropCount=0 after edge; inReady=0 during reset.
REQ-037 enable=0 with inValid=1 -> inReady=0, no load, existing FULL slots still drain on outReady.
